cic_monitor_scanner: RTL and testbench

Sequencer that owns `digital_monitor_sel` of the CIC3 decimator and scans the enabled monitor taps automatically. For each tap it selects the channel and waits a programmable settle time. It then captures the 25-bit `digital_monitor` word and presents it, tagged with its channel number, on a valid/ready port. It sits between `cic3_echip65` and the chip readout/SPI logic, replacing direct host control of the monitor mux.

---
 rtl/cic_monitor_scanner.sv | 187 ++++++++++++++++++
 tb/tb_cic_monitor_scanner.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_monitor_scanner.sv
// Automatic scanner for the CIC3 monitor mux: walks the enabled taps, waits the settle time,
// captures each monitor word and hands it to the readout over a one-deep valid/ready slot.
module cic_monitor_scanner #(
  parameter int NUM_CH  = 16,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 25,
  parameter int DWELL_W = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               single_shot,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [DATA_W-1:0]  digital_monitor,
  output logic [SEL_W-1:0]   digital_monitor_sel,
  output logic [DATA_W-1:0]  sample_data,
  output logic [SEL_W-1:0]   sample_ch,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               scan_done,
  output logic               overflow,
  input  logic               clear_overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEEK    = 2'd1,
    S_SETTLE  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [SEL_W-1:0]   seek_idx;
  logic               hi_found;
  logic [SEL_W-1:0]   hi_idx;
  logic [SEL_W-1:0]   lo_idx;
  logic [NUM_CH-1:0]  above_vec;
  logic               pass_end;
  logic               pop;
  logic               mask_any;

  assign mask_any = |ch_mask;
  assign pop      = valid_q & sample_ready;

  // Lowest set mask bit at or above ptr, falling back to the lowest set bit overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo_idx = SEL_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    seek_idx = hi_found ? hi_idx : lo_idx;
  end

  // The pass ends when the latched mask has nothing above the channel being captured.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_above
      assign above_vec[gi] = mask_q[gi] && (SEL_W'(gi) > sel_q);
    end
  endgenerate
  assign pass_end = ~|above_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable && mask_any) state_d = S_SEEK;
      end
      S_SEEK: begin
        if (!enable || !mask_any) state_d = S_IDLE;
        else                      state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!enable)           state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!enable)                     state_d = S_IDLE;
        else if (pass_end && single_shot) state_d = S_IDLE;
        else                             state_d = S_SEEK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (pop)            valid_d = 1'b0;
    if (clear_overflow) ovf_d   = 1'b0;

    case (state_q)
      S_SEEK: begin
        if (enable && mask_any) begin
          sel_d  = seek_idx;
          cnt_d  = dwell_cycles;
          mask_d = ch_mask;
        end
      end
      S_SETTLE: begin
        if (enable && cnt_q != '0) cnt_d = cnt_q - DWELL_W'(1);
      end
      S_CAPTURE: begin
        if (enable) begin
          if (!valid_q || pop) begin
            data_d  = digital_monitor;
            ch_d    = sel_q;
            valid_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          ptr_d  = sel_q + SEL_W'(1);
          done_d = pass_end;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign digital_monitor_sel = sel_q;
  assign sample_data         = data_q;
  assign sample_ch           = ch_q;
  assign sample_valid        = valid_q;
  assign scan_done           = done_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_cic_monitor_scanner.sv
// Self-checking bench for cic_monitor_scanner: table of single-pass scans, hand-written corner
// sequences, and a randomized run against a schedule-based reference model.
module tb_cic_monitor_scanner;

  localparam int NUM_CH  = 16;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 25;
  localparam int DWELL_W = 20;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               single_shot;
  logic [NUM_CH-1:0]  ch_mask;
  logic [DWELL_W-1:0] dwell_cycles;
  logic [DATA_W-1:0]  digital_monitor;
  logic [SEL_W-1:0]   digital_monitor_sel;
  logic [DATA_W-1:0]  sample_data;
  logic [SEL_W-1:0]   sample_ch;
  logic               sample_valid;
  logic               sample_ready;
  logic               scan_done;
  logic               overflow;
  logic               clear_overflow;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] dm_prev;
  logic              rdy_prev;
  logic              clr_prev;

  cic_monitor_scanner #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .DATA_W (DATA_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .single_shot        (single_shot),
    .ch_mask            (ch_mask),
    .dwell_cycles       (dwell_cycles),
    .digital_monitor    (digital_monitor),
    .digital_monitor_sel(digital_monitor_sel),
    .sample_data        (sample_data),
    .sample_ch          (sample_ch),
    .sample_valid       (sample_valid),
    .sample_ready       (sample_ready),
    .scan_done          (scan_done),
    .overflow           (overflow),
    .clear_overflow     (clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                dwell;
    int                exp_count;
    int                exp_first;
    int                exp_last;
    int                exp_lat;
    int                exp_period;
    int                exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Remember what the DUT sees at the coming edge, then sample 1 time unit after it.
  task automatic tick();
    dm_prev  = digital_monitor;
    rdy_prev = sample_ready;
    clr_prev = clear_overflow;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   32'(digital_monitor_sel), 32'd0);
    check({tag, "_data"},  32'(sample_data), 32'd0);
    check({tag, "_ch"},    32'(sample_ch), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_done"},  32'(scan_done), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  task automatic do_reset(input bit check_it);
    reset_n         = 1'b0;
    enable          = 1'b0;
    single_shot     = 1'b0;
    ch_mask         = '0;
    dwell_cycles    = '0;
    digital_monitor = '0;
    sample_ready    = 1'b0;
    clear_overflow  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_it) check_reset_outputs("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt, dn, first_ch, last_ch, lat, prev_t, exp_idx, last_done, first_cap, cap_ch, seen;
    logic [DATA_W-1:0] d5;
    int lst[$];
    logic [NUM_CH-1:0] m;
    int dw, per, nch, k, c, sel_e, sc;
    bit sv, ov, done_e, set_ov;
    logic [DATA_W-1:0] sd;

    vecs[0] = '{16'h0005, 4, 2,  0,  2,  7, 7, 1};
    vecs[1] = '{16'h8000, 0, 1, 15, 15,  3, 3, 1};
    vecs[2] = '{16'h0000, 3, 0,  0,  0,  0, 0, 0};
    vecs[3] = '{16'h0110, 2, 2,  4,  8,  5, 5, 1};
    vecs[4] = '{16'hFFFF, 0, 16, 0, 15,  3, 3, 1};

    do_reset(1);

    // Single-shot passes from the table; enable is dropped once scan_done is seen.
    for (int r = 0; r < 5; r++) begin
      do_reset(0);
      ch_mask      = vecs[r].mask;
      dwell_cycles = DWELL_W'(vecs[r].dwell);
      single_shot  = 1'b1;
      sample_ready = 1'b1;
      enable       = 1'b1;
      cnt = 0; dn = 0; first_ch = -1; last_ch = -1; lat = -1; prev_t = -1;
      for (int t = 0; t < 120; t++) begin
        digital_monitor = DATA_W'($urandom);
        tick();
        if (sample_valid) begin
          cnt++;
          check("tbl_data", 32'(sample_data), 32'(dm_prev));
          if (lat < 0) lat = t;
          else check("tbl_spacing", 32'(t - prev_t), 32'(vecs[r].exp_period));
          prev_t = t;
          if (first_ch < 0) first_ch = int'(sample_ch);
          last_ch = int'(sample_ch);
        end
        if (scan_done) begin
          dn++;
          enable = 1'b0;
        end
      end
      check("tbl_count", 32'(cnt), 32'(vecs[r].exp_count));
      check("tbl_done", 32'(dn), 32'(vecs[r].exp_done));
      if (vecs[r].exp_count > 0) begin
        check("tbl_first_ch", 32'(first_ch), 32'(vecs[r].exp_first));
        check("tbl_last_ch", 32'(last_ch), 32'(vecs[r].exp_last));
        check("tbl_latency", 32'(lat), 32'(vecs[r].exp_lat));
      end
      $display("table row %0d mask=%h dwell=%0d samples=%0d done=%0d", r, vecs[r].mask,
               vecs[r].dwell, cnt, dn);
    end

    // Full loop: channels 0..15 repeating, scan_done every 16*13 clocks.
    do_reset(0);
    ch_mask = 16'hFFFF; dwell_cycles = DWELL_W'(10); single_shot = 1'b0;
    sample_ready = 1'b1; enable = 1'b1;
    exp_idx = 0; last_done = -1; dn = 0;
    for (int t = 0; t < 441; t++) begin
      digital_monitor = DATA_W'($urandom);
      tick();
      if (sample_valid) begin
        check("loop_ch", 32'(sample_ch), 32'(exp_idx % 16));
        check("loop_data", 32'(sample_data), 32'(dm_prev));
        exp_idx++;
      end
      if (scan_done) begin
        dn++;
        if (last_done < 0) check("loop_first_done", 32'(t), 32'd208);
        else check("loop_done_period", 32'(t - last_done), 32'd208);
        last_done = t;
      end
    end
    check("loop_samples", 32'(exp_idx), 32'd33);
    check("loop_dones", 32'(dn), 32'd2);
    $display("full loop samples=%0d done=%0d", exp_idx, dn);

    // Backpressure: held sample, dropped capture, clear, then pop+capture in one cycle.
    do_reset(0);
    ch_mask = 16'h0003; dwell_cycles = DWELL_W'(2); single_shot = 1'b0;
    sample_ready = 1'b0; enable = 1'b1;
    d5 = '0;
    for (int t = 0; t <= 10; t++) begin
      digital_monitor = DATA_W'($urandom);
      tick();
      if (t == 5) d5 = dm_prev;
    end
    check("bp_valid_held", 32'(sample_valid), 32'd1);
    check("bp_ch_held", 32'(sample_ch), 32'd0);
    check("bp_data_held", 32'(sample_data), 32'(d5));
    check("bp_overflow_set", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("bp_overflow_clr", 32'(overflow), 32'd0);
    repeat (3) tick();
    sample_ready = 1'b1;
    digital_monitor = DATA_W'($urandom);
    tick();
    sample_ready = 1'b0;
    check("bp_popcap_valid", 32'(sample_valid), 32'd1);
    check("bp_popcap_ch", 32'(sample_ch), 32'd0);
    check("bp_popcap_data", 32'(sample_data), 32'(dm_prev));
    check("bp_popcap_ovf", 32'(overflow), 32'd0);
    repeat (5) tick();
    check("bp_second_drop", 32'(overflow), 32'd1);
    $display("backpressure sequence ch=%0d ovf=%0b", sample_ch, overflow);

    // Abort 50 cycles into SETTLE, then resume.
    do_reset(0);
    ch_mask = 16'h0010; dwell_cycles = DWELL_W'(100); single_shot = 1'b0;
    sample_ready = 1'b1; enable = 1'b1;
    repeat (52) tick();
    check("abort_sel", 32'(digital_monitor_sel), 32'd4);
    enable = 1'b0;
    seen = 0;
    for (int t = 0; t < 150; t++) begin
      tick();
      if (sample_valid) seen++;
    end
    check("abort_no_sample", 32'(seen), 32'd0);
    check("abort_sel_hold", 32'(digital_monitor_sel), 32'd4);
    enable = 1'b1;
    first_cap = -1; cap_ch = -1;
    for (int t = 0; t < 111; t++) begin
      tick();
      if (sample_valid && first_cap < 0) begin
        first_cap = t;
        cap_ch = int'(sample_ch);
      end
    end
    check("resume_latency", 32'(first_cap), 32'd103);
    check("resume_ch", 32'(cap_ch), 32'd4);
    $display("abort/resume capture at %0d ch=%0d", first_cap, cap_ch);

    // Single top channel: every capture ends a pass.
    do_reset(0);
    ch_mask = 16'h8000; dwell_cycles = DWELL_W'(1); single_shot = 1'b0;
    sample_ready = 1'b1; enable = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick();
      check("top_done", 32'(scan_done), 32'((t >= 4 && t % 4 == 0) ? 1 : 0));
      check("top_valid", 32'(sample_valid), 32'((t >= 4 && t % 4 == 0) ? 1 : 0));
      if (sample_valid) check("top_ch", 32'(sample_ch), 32'd15);
    end
    $display("top channel sequence done");

    // Asynchronous reset while in CAPTURE with non-zero outputs.
    do_reset(0);
    ch_mask = 16'h0002; dwell_cycles = DWELL_W'(2); single_shot = 1'b0;
    sample_ready = 1'b0; enable = 1'b1;
    repeat (15) tick();
    check("pre_rst_valid", 32'(sample_valid), 32'd1);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    check("pre_rst_sel", 32'(digital_monitor_sel), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    $display("async reset in capture checked");

    // Randomized configurations against the schedule model.
    for (int cfg = 0; cfg < 4; cfg++) begin
      do_reset(0);
      m = NUM_CH'($urandom);
      if (m == '0) m = 16'h0001;
      dw = $urandom_range(0, 6);
      lst.delete();
      for (int i = 0; i < NUM_CH; i++) if (m[i]) lst.push_back(i);
      per = dw + 3;
      nch = lst.size();
      ch_mask = m; dwell_cycles = DWELL_W'(dw); single_shot = 1'b0; enable = 1'b1;
      sv = 0; ov = 0; sd = '0; sc = 0;
      sample_ready    = 1'($urandom);
      clear_overflow  = ($urandom_range(0, 7) == 0);
      digital_monitor = DATA_W'($urandom);
      for (int t = 0; t < 250; t++) begin
        tick();
        done_e = 0; set_ov = 0;
        if (t >= per && t % per == 0) begin
          k = t / per - 1;
          c = lst[k % nch];
          done_e = (k % nch == nch - 1);
          if (!sv || rdy_prev) begin
            sv = 1; sd = dm_prev; sc = c;
          end else begin
            set_ov = 1;
          end
        end else if (sv && rdy_prev) begin
          sv = 0;
        end
        ov = set_ov ? 1'b1 : (clr_prev ? 1'b0 : ov);
        sel_e = (t >= 1) ? lst[((t - 1) / per) % nch] : 0;
        check("rnd_sel", 32'(digital_monitor_sel), 32'(sel_e));
        check("rnd_valid", 32'(sample_valid), 32'(sv));
        check("rnd_done", 32'(scan_done), 32'(done_e));
        check("rnd_ovf", 32'(overflow), 32'(ov));
        if (sv) begin
          check("rnd_data", 32'(sample_data), 32'(sd));
          check("rnd_ch", 32'(sample_ch), 32'(sc));
        end
        sample_ready    = 1'($urandom);
        clear_overflow  = ($urandom_range(0, 7) == 0);
        digital_monitor = DATA_W'($urandom);
      end
      $display("random cfg %0d mask=%h dwell=%0d", cfg, m, dw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
